uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// A byte held at the end of a stop bit is started on the same edge, so back-to-back frames have no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] iTXdata,
  input  logic       iTXvalid,
  output logic       oTXready,
  output logic       oTX,
  output logic       oBusy,
  output logic       oDone
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       hold_q;
  logic             hold_full_q, hold_full_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             accept;
  logic             load;
  logic             shift_en;
  logic             bit_end;

  // Ready depends only on the holding flag, so accept and load can never share an edge.
  assign oTXready = ~hold_full_q;
  assign accept   = iTXvalid & ~hold_full_q;
  assign bit_end  = (baud_q == CNT_LAST);
  assign oTX      = tx_q;
  assign oBusy    = (state_q != IDLE);
  assign oDone    = done_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_en = 1'b1;
            tx_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  // Payload registers carry no reset; their contents are qualified by hold_full_q and state_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= iTXdata;
    end
    if (load) begin
      shift_q <= hold_q;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frame, back-to-back with backpressure, mid-frame reset,
// plus a line decoder that recovers the transmitted bytes from oTX.
module tb_uart_tx;

  localparam int CPB = 50;

  logic       clk;
  logic       rst_n;
  logic [7:0] iTXdata;
  logic       iTXvalid;
  logic       oTXready;
  logic       oTX;
  logic       oBusy;
  logic       oDone;

  int n_total  = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [7:0] rx_q[$];
  logic       rx_act;
  int         rx_cnt;
  int         rx_bit;
  logic [7:0] rx_sh;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iTXdata  (iTXdata),
    .iTXvalid (iTXvalid),
    .oTXready (oTXready),
    .oTX      (oTX),
    .oBusy    (oBusy),
    .oDone    (oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Line decoder: mid-bit sampling of oTX, frames aborted by reset are dropped.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (oTX === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 0;
        rx_bit <= 0;
      end
    end else begin
      if (rx_cnt == CPB - 1) begin
        rx_cnt <= 0;
        rx_bit <= rx_bit + 1;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
      if (rx_cnt == CPB / 2 - 1) begin
        if (rx_bit >= 1 && rx_bit <= 8) begin
          rx_sh <= {oTX, rx_sh[7:1]};
        end else if (rx_bit == 9) begin
          rx_act <= 1'b0;
          if (oTX === 1'b1) rx_q.push_back(rx_sh);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (oDone === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows the accept edge.
  task automatic offer(input logic [7:0] b, input int limit, output int waited);
    iTXdata  = b;
    iTXvalid = 1'b1;
    waited   = 0;
    while (!oTXready && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    iTXvalid = 1'b0;
  endtask

  // Samples every cycle of a frame whose start bit begins on the next rising edge.
  task automatic expect_frame(input logic [7:0] b, input logic first_done);
    logic [9:0] bits;
    logic       exp_done;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        exp_done = (i == 0 && k == 0) ? first_done : 1'b0;
        chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, i, k),
            32'({oTX, oBusy, oDone}), 32'({bits[i], 1'b1, exp_done}));
        if (i == 0 && k == 0) chk($sformatf("frame_%02h_ready_at_start", b), 32'(oTXready), 32'd1);
      end
    end
  endtask

  task automatic expect_end(input string tag, input int idle_cycles);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'({oTX, oBusy, oDone}), 32'(3'b101));
    for (int i = 0; i < idle_cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s_idle_%0d", tag, i), 32'({oTX, oTXready, oBusy, oDone}), 32'(4'b1100));
    end
  endtask

  initial begin
    int w;
    int w1;
    int w2;
    logic [7:0] exp_bytes [5];
    exp_bytes[0] = 8'h34;
    exp_bytes[1] = 8'h34;
    exp_bytes[2] = 8'h38;
    exp_bytes[3] = 8'h32;
    exp_bytes[4] = 8'h55;

    rst_n    = 1'b0;
    iTXvalid = 1'b0;
    iTXdata  = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("reset_hold_%0d", i), 32'({oTX, oTXready, oBusy, oDone}), 32'(4'b1100));
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", 32'({oTX, oTXready, oBusy, oDone}), 32'(4'b1100));

    // Single byte 0x34
    offer(8'h34, 10, w);
    chk("single_accept_wait", 32'(w), 32'd0);
    chk("single_ready_low", 32'(oTXready), 32'd0);
    expect_frame(8'h34, 1'b0);
    expect_end("single", 5);

    // Back-to-back 0x34, 0x38 with 0x32 held off by a full holding register
    offer(8'h34, 10, w);
    chk("b2b_ready_low", 32'(oTXready), 32'd0);
    fork
      begin
        expect_frame(8'h34, 1'b0);
        expect_frame(8'h38, 1'b1);
        expect_frame(8'h32, 1'b1);
      end
      begin
        offer(8'h38, 20, w1);
        offer(8'h32, 600, w2);
      end
    join
    chk("b2b_second_wait", 32'(w1), 32'd1);
    chk("backpressure_wait", 32'(w2), 32'd499);
    expect_end("b2b", 20);

    // Mid-frame reset during data bit 3 with a byte waiting in holding
    offer(8'h34, 10, w);
    offer(8'h38, 20, w);
    chk("abort_hold_wait", 32'(w), 32'd1);
    repeat (223) @(negedge clk);
    chk("abort_bit3_line", 32'({oTX, oBusy}), 32'(2'b01));
    #1 rst_n = 1'b0;
    #1 chk("abort_immediate", 32'({oTX, oTXready, oBusy, oDone}), 32'(4'b1100));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("abort_reset_%0d", i), 32'({oTX, oTXready, oBusy, oDone}), 32'(4'b1100));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("abort_discard_%0d", i), 32'({oTX, oTXready, oBusy, oDone}), 32'(4'b1100));
    end
    offer(8'h55, 10, w);
    chk("fresh_accept_wait", 32'(w), 32'd0);
    chk("fresh_ready_low", 32'(oTXready), 32'd0);
    expect_frame(8'h55, 1'b0);
    expect_end("fresh", 5);

    chk("done_pulse_count", 32'(done_cnt), 32'd5);
    chk("decoded_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) chk($sformatf("decoded_byte_%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
